// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the 11-bit maze LFSR (taps 11,9).
// Self-synchronises on incoming valid words, then predicts each next word.
// A mismatch while locked raises a one-cycle pulse and bumps a saturating error count.
module lfsr_sequence_checker #(
    parameter int unsigned LOCK_MATCHES  = 4,
    parameter int unsigned UNLOCK_ERRORS = 3,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [10:0]          in_data,
    input  logic                 in_valid,
    input  logic                 clear_errors,
    output logic                 locked,
    output logic                 error_pulse,
    output logic [CNT_WIDTH-1:0] error_count,
    output logic [10:0]          expected
);

    localparam logic [3:0] LockMatchesW  = 4'(LOCK_MATCHES);
    localparam logic [3:0] UnlockErrorsW = 4'(UNLOCK_ERRORS);

    typedef enum logic [1:0] {
        StIdle,
        StAcquire,
        StLocked
    } state_e;

    function automatic logic [10:0] step(input logic [10:0] x);
        return {x[9:0], x[10] ^ x[8]};
    endfunction

    state_e               state_q, state_d;
    logic [10:0]          prev_q, prev_d;
    logic [3:0]           mcnt_q, mcnt_d;
    logic [3:0]           ecnt_q, ecnt_d;
    logic                 pulse_q, pulse_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 locked_q, locked_d;
    logic [10:0]          expected_q, expected_d;

    logic [10:0] pred;
    logic [3:0]  mcnt_inc;
    logic [3:0]  ecnt_inc;
    logic        count_err;

    assign pred     = step(prev_q);
    assign mcnt_inc = mcnt_q + 4'd1;
    assign ecnt_inc = ecnt_q + 4'd1;

    // Next-state: sequence tracking FSM, error counting and registered outputs.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        mcnt_d    = mcnt_q;
        ecnt_d    = ecnt_q;
        pulse_d   = 1'b0;
        count_err = 1'b0;

        if (in_valid) begin
            case (state_q)
                StIdle: begin
                    // An all-zero word is the LFSR lock-up state; never seed from it.
                    if (in_data != 11'd0) begin
                        prev_d  = in_data;
                        mcnt_d  = 4'd0;
                        state_d = StAcquire;
                    end
                end
                StAcquire: begin
                    if (in_data == pred) begin
                        prev_d = in_data;
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc == LockMatchesW) begin
                            state_d = StLocked;
                            ecnt_d  = 4'd0;
                        end
                    end else if (in_data != 11'd0) begin
                        prev_d = in_data;
                        mcnt_d = 4'd0;
                    end else begin
                        state_d = StIdle;
                        prev_d  = 11'd0;
                        mcnt_d  = 4'd0;
                    end
                end
                StLocked: begin
                    if (in_data == pred) begin
                        prev_d = in_data;
                        ecnt_d = 4'd0;
                    end else begin
                        // Flywheel: keep advancing our own prediction rather than re-seeding
                        // from a word that is known to be corrupt.
                        prev_d    = pred;
                        pulse_d   = 1'b1;
                        count_err = 1'b1;
                        ecnt_d    = ecnt_inc;
                        if (ecnt_inc == UnlockErrorsW) begin
                            state_d = StIdle;
                            prev_d  = 11'd0;
                            mcnt_d  = 4'd0;
                            ecnt_d  = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    prev_d  = 11'd0;
                    mcnt_d  = 4'd0;
                    ecnt_d  = 4'd0;
                end
            endcase
        end

        // Clear beats a coincident counted error.
        cnt_d = cnt_q;
        if (clear_errors) begin
            cnt_d = '0;
        end else if (count_err && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        locked_d   = (state_d == StLocked);
        expected_d = (state_d == StIdle) ? 11'd0 : step(prev_d);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            prev_q     <= 11'd0;
            mcnt_q     <= 4'd0;
            ecnt_q     <= 4'd0;
            pulse_q    <= 1'b0;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            expected_q <= 11'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            mcnt_q     <= mcnt_d;
            ecnt_q     <= ecnt_d;
            pulse_q    <= pulse_d;
            cnt_q      <= cnt_d;
            locked_q   <= locked_d;
            expected_q <= expected_d;
        end
    end

    assign locked      = locked_q;
    assign error_pulse = pulse_q;
    assign error_count = cnt_q;
    assign expected    = expected_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Directed bench for lfsr_sequence_checker: default instance plus a narrow-counter
// instance (CNT_WIDTH=2, UNLOCK_ERRORS=15) for saturation, sharing one stimulus stream.
module tb_lfsr_sequence_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] in_data = 11'd0;
    logic        in_valid = 1'b0;
    logic        clear_errors = 1'b0;

    logic        locked_a, pulse_a;
    logic [15:0] count_a;
    logic [10:0] exp_a;
    logic        locked_b, pulse_b;
    logic [1:0]  count_b;
    logic [10:0] exp_b;

    int errors = 0;
    int checks = 0;

    lfsr_sequence_checker dut_a (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .clear_errors (clear_errors),
        .locked       (locked_a),
        .error_pulse  (pulse_a),
        .error_count  (count_a),
        .expected     (exp_a)
    );

    lfsr_sequence_checker #(
        .LOCK_MATCHES  (4),
        .UNLOCK_ERRORS (15),
        .CNT_WIDTH     (2)
    ) dut_b (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .clear_errors (clear_errors),
        .locked       (locked_b),
        .error_pulse  (pulse_b),
        .error_count  (count_b),
        .expected     (exp_b)
    );

    always #5 clock = ~clock;

    function automatic logic [10:0] step(input logic [10:0] x);
        return {x[9:0], x[10] ^ x[8]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, then let outputs settle just past the rising edge.
    task automatic cyc(input logic v, input logic [10:0] d, input logic clr, input logic rst);
        @(negedge clock);
        in_valid     = v;
        in_data      = d;
        clear_errors = clr;
        reset        = rst;
        @(posedge clock);
        #1;
        in_valid     = 1'b0;
        clear_errors = 1'b0;
        reset        = 1'b0;
    endtask

    logic [10:0] w;

    initial begin
        // Reset state
        cyc(1'b0, 11'd0, 1'b0, 1'b1);
        check("rst_locked", 32'(locked_a), 32'd0);
        check("rst_pulse", 32'(pulse_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_expected", 32'(exp_a), 32'd0);

        // Lock: 0x555, 0x2AA, 0x554, ...
        cyc(1'b1, 11'h555, 1'b0, 1'b0);
        check("lock_w1_locked", 32'(locked_a), 32'd0);
        check("lock_w1_expected", 32'(exp_a), 32'h2AA);
        cyc(1'b1, 11'h2AA, 1'b0, 1'b0);
        check("lock_w2_locked", 32'(locked_a), 32'd0);
        check("lock_w2_expected", 32'(exp_a), 32'h554);
        w = 11'h2AA;
        for (int i = 3; i <= 5; i++) begin
            w = step(w);
            cyc(1'b1, w, 1'b0, 1'b0);
            check($sformatf("lock_w%0d_locked", i), 32'(locked_a), (i == 5) ? 32'd1 : 32'd0);
            check($sformatf("lock_w%0d_expected", i), 32'(exp_a), 32'(step(w)));
            check($sformatf("lock_w%0d_pulse", i), 32'(pulse_a), 32'd0);
        end
        check("lock_count", 32'(count_a), 32'd0);
        check("lock_b_locked", 32'(locked_b), 32'd1);

        // Single error, then the true chain resumes and matches the flywheel
        w = step(w);
        cyc(1'b1, 11'd0, 1'b0, 1'b0);
        check("err1_pulse", 32'(pulse_a), 32'd1);
        check("err1_count", 32'(count_a), 32'd1);
        check("err1_locked", 32'(locked_a), 32'd1);
        check("err1_expected", 32'(exp_a), 32'(step(w)));
        w = step(w);
        cyc(1'b1, w, 1'b0, 1'b0);
        check("resume_pulse", 32'(pulse_a), 32'd0);
        check("resume_count", 32'(count_a), 32'd1);
        check("resume_expected", 32'(exp_a), 32'(step(w)));

        // Clear with no valid word: count drops, lock holds
        cyc(1'b0, 11'd0, 1'b1, 1'b0);
        check("clear_count", 32'(count_a), 32'd0);
        check("clear_locked", 32'(locked_a), 32'd1);

        // Loss of lock: three consecutive wrong words
        for (int i = 1; i <= 3; i++) begin
            w = step(w);
            cyc(1'b1, 11'd0, 1'b0, 1'b0);
            check($sformatf("loss%0d_pulse", i), 32'(pulse_a), 32'd1);
            check($sformatf("loss%0d_count", i), 32'(count_a), 32'(i));
            check($sformatf("loss%0d_locked", i), 32'(locked_a), (i == 3) ? 32'd0 : 32'd1);
        end
        check("loss_expected", 32'(exp_a), 32'd0);
        cyc(1'b0, 11'd0, 1'b0, 1'b0);
        check("loss_pulse_drop", 32'(pulse_a), 32'd0);
        check("loss_count_keep", 32'(count_a), 32'd3);

        // Acquire re-seed with gaps
        cyc(1'b1, 11'h555, 1'b0, 1'b0);
        check("acq_seed_expected", 32'(exp_a), 32'h2AA);
        cyc(1'b0, 11'h2AA, 1'b0, 1'b0);
        check("acq_gap_expected", 32'(exp_a), 32'h2AA);
        cyc(1'b1, 11'h123, 1'b0, 1'b0);
        check("acq_reseed_pulse", 32'(pulse_a), 32'd0);
        check("acq_reseed_expected", 32'(exp_a), 32'(step(11'h123)));
        w = 11'h123;
        for (int i = 1; i <= 4; i++) begin
            w = step(w);
            cyc(1'b1, w, 1'b0, 1'b0);
            check($sformatf("acq_m%0d_locked", i), 32'(locked_a), (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("acq_m%0d_pulse", i), 32'(pulse_a), 32'd0);
            cyc(1'b0, 11'd0, 1'b0, 1'b0);
            check($sformatf("acq_gap%0d_expected", i), 32'(exp_a), 32'(step(w)));
            check($sformatf("acq_gap%0d_locked", i), 32'(locked_a), (i == 4) ? 32'd1 : 32'd0);
        end
        check("acq_count", 32'(count_a), 32'd3);

        // Reset mid-lock wins over a mismatching valid word
        cyc(1'b1, 11'd0, 1'b0, 1'b1);
        check("midrst_locked", 32'(locked_a), 32'd0);
        check("midrst_pulse", 32'(pulse_a), 32'd0);
        check("midrst_count", 32'(count_a), 32'd0);
        check("midrst_expected", 32'(exp_a), 32'd0);

        // Saturation and clear on the narrow instance
        w = 11'h555;
        cyc(1'b1, w, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = step(w);
            cyc(1'b1, w, 1'b0, 1'b0);
        end
        check("sat_b_locked", 32'(locked_b), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 11'd0, 1'b0, 1'b0);
            check($sformatf("sat%0d_pulse", i), 32'(pulse_b), 32'd1);
            check($sformatf("sat%0d_count", i), 32'(count_b), (i >= 3) ? 32'd3 : 32'(i));
        end
        cyc(1'b1, 11'd0, 1'b1, 1'b0);
        check("satclr_pulse", 32'(pulse_b), 32'd1);
        check("satclr_count", 32'(count_b), 32'd0);
        check("satclr_locked", 32'(locked_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lfsr_sequence_checker.md
# lfsr_sequence_checker

Receive-side companion to the 11-bit maze LFSR generator. It samples a stream of 11-bit words qualified by a valid strobe and self-synchronises by seeding its own predictor from the incoming data. Once locked, it predicts every next word and reports mismatches and a saturating error count. It sits on the consumer side of any LFSR-driven path: random maze/tile selection, or bench-level checking of the generator.

## Interface
- LOCK_MATCHES, 4: consecutive correct predictions required to enter LOCKED (legal range 1..15).
- UNLOCK_ERRORS, 3: consecutive mispredictions in LOCKED that force loss of lock (legal range 1..15).
- CNT_WIDTH, 16: width of error_count.

- clock  input  1  rising-edge clock, the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- in_data  input  11  word under test; sampled only when in_valid=1.
- in_valid  input  1  qualifies in_data for one clock.
- clear_errors  input  1  synchronous clear of error_count.
- locked  output  1  high while in LOCKED.
- error_pulse  output  1  one-cycle pulse per mispredicted word while LOCKED.
- error_count  output  CNT_WIDTH  saturating count of mispredictions while LOCKED.
- expected  output  11  word the block will compare against on the next valid sample; 0 in IDLE.

## Operation
- Step function, identical to the generator (taps 11,9): step(x) = {x[9:0], x[10]^x[8]}.
- Reference register prev[10:0], match counter mcnt, error-run counter ecnt; expected = step(prev) outside IDLE.
- States: IDLE, ACQUIRE, LOCKED. Inputs are acted on only when in_valid=1; otherwise all state holds and error_pulse=0.
- IDLE, valid word:
  - in_data==0 (lock-up word): stay in IDLE.
  - otherwise: prev<=in_data, mcnt<=0, go to ACQUIRE.
- ACQUIRE, valid word:
  - in_data==step(prev): prev<=in_data, mcnt<=mcnt+1; if mcnt+1==LOCK_MATCHES, go to LOCKED with ecnt<=0.
  - mismatch, nonzero data: re-seed with prev<=in_data, mcnt<=0, stay in ACQUIRE.
  - mismatch, zero data: go to IDLE.
  - No error_pulse and no count in ACQUIRE.
- LOCKED, valid word:
  - match: prev<=in_data, ecnt<=0.
  - mismatch (flywheel): prev<=step(prev), so the prediction advances and does not re-seed; error_pulse<=1; error_count increments, saturating at all-ones; ecnt<=ecnt+1.
  - If ecnt+1==UNLOCK_ERRORS, go to IDLE: locked<=0, prev<=0, mcnt<=0, ecnt<=0. That last mismatch still pulses and counts.
- clear_errors:
  - error_count<=0 on the next edge.
  - If it coincides with a counted error, the clear wins and the count becomes 0.
  - It has no effect on the state machine.
- error_count is changed only by reset, clear_errors, or a counted mismatch. It persists across loss of lock.

## Timing
- All outputs are registered. Response appears on the clock edge that samples in_valid and is visible during the following cycle. Latency is 1.
- locked rises in the cycle after the LOCK_MATCHES-th consecutive match. That is LOCK_MATCHES+1 valid words after IDLE, counting the seed word.
- error_pulse is high for exactly one cycle per counted mismatch. It can be high on back-to-back cycles.
- Gaps in in_valid of any length are transparent; only valid words advance the sequence.
- Reset values: state=IDLE, locked=0, error_pulse=0, error_count=0, expected=0, prev/mcnt/ecnt=0.
- Reset asserted mid-operation overrides every other input on that edge, including a simultaneous in_valid or clear_errors.

## Test plan
- Lock: reset, then feed 0x555, 0x2AA, 0x554, … (a continuous step() chain) one per clock → locked=0 through the 5th word; locked=1 in the cycle after the 5th; expected tracks step(last word); error_count=0.
- Single error: after lock, replace one word with 0x000, then resume the true chain → one error_pulse, error_count=1, locked stays 1. The next correct word matches, because the flywheel prediction advanced.
- Loss of lock: after lock, feed 3 consecutive wrong words → 3 pulses, error_count=3; locked falls in the cycle after the 3rd; expected=0.
- Acquire re-seed and gaps: feed 0x555, then 0x123 (mismatch), then the chain from 0x123, with in_valid toggling 1/0 → no pulses; locked=1 only after 4 further matches from 0x123; idle cycles change nothing.
- Saturation and clear: CNT_WIDTH=2 with UNLOCK_ERRORS=15; feed 5 mismatches → count goes 1,2,3,3,3. Then assert clear_errors together with a 6th mismatch → error_pulse=1, error_count=0.
- Reset mid-lock: assert reset on an edge with in_valid=1 and a mismatching word → next cycle locked=0, error_pulse=0, error_count=0, expected=0.
